// File: rtl/load_ext_unit.sv
// load_ext_unit: handles a load request from the MEM stage. It checks alignment, issues one
// word read on the data bus, and waits a bounded number of cycles for the acknowledge. It then
// returns the aligned and sign- or zero-extended result together with an exception code.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_addr, req_ltype    byte address, load type (000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu,
//                          101-111 treated as lw)
//   bus_rd                 read strobe, held until ack or timeout
//   bus_addr, bus_be       word address and little-endian byte lanes of the read
//   bus_ack, bus_rdata     read data valid strobe and data
//   rsp_valid              one-cycle result strobe
//   rsp_data, rsp_exc      result and exception code (00 none, 01 misaligned, 10 timeout),
//                          held until the next response
//   busy                   unit is not idle
module load_ext_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_ltype,
  output logic        bus_rd,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_exc,
  output logic        busy
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] LtH  = 3'b001;
  localparam logic [2:0] LtHu = 3'b010;
  localparam logic [2:0] LtB  = 3'b011;
  localparam logic [2:0] LtBu = 3'b100;

  localparam logic [1:0] ExcNone    = 2'b00;
  localparam logic [1:0] ExcMis     = 2'b01;
  localparam logic [1:0] ExcTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      lsb_q, lsb_d;
  logic [2:0]      ltype_q, ltype_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_exc_q, rsp_exc_d;

  // Request decode: size class, alignment and byte lanes.
  logic       req_is_h, req_is_b, req_is_w;
  logic       req_mis;
  logic [3:0] req_be;

  always_comb begin
    req_is_h = (req_ltype == LtH) || (req_ltype == LtHu);
    req_is_b = (req_ltype == LtB) || (req_ltype == LtBu);
    req_is_w = !req_is_h && !req_is_b;
    req_mis  = (req_is_w && (req_addr[1:0] != 2'b00)) || (req_is_h && req_addr[0]);
    if (req_is_b) begin
      req_be = 4'b0001 << req_addr[1:0];
    end else if (req_is_h) begin
      req_be = req_addr[1] ? 4'b1100 : 4'b0011;
    end else begin
      req_be = 4'b1111;
    end
  end

  // Extraction from the returned word using the latched address bits and load type.
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  always_comb begin
    case (lsb_q)
      2'd0:    sel_byte = bus_rdata[7:0];
      2'd1:    sel_byte = bus_rdata[15:8];
      2'd2:    sel_byte = bus_rdata[23:16];
      default: sel_byte = bus_rdata[31:24];
    endcase
    sel_half = lsb_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ltype_q)
      LtH:     ext_data = {{16{sel_half[15]}}, sel_half};
      LtHu:    ext_data = {16'h0000, sel_half};
      LtB:     ext_data = {{24{sel_byte[7]}}, sel_byte};
      LtBu:    ext_data = {24'h000000, sel_byte};
      default: ext_data = bus_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lsb_d      = lsb_q;
    ltype_d    = ltype_q;
    bus_addr_d = bus_addr_q;
    bus_be_d   = bus_be_q;
    rsp_data_d = rsp_data_q;
    rsp_exc_d  = rsp_exc_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          lsb_d   = req_addr[1:0];
          ltype_d = req_ltype;
          cnt_d   = '0;
          if (req_mis) begin
            // Misaligned loads never touch the bus.
            state_d    = StResp;
            rsp_data_d = 32'h0;
            rsp_exc_d  = ExcMis;
          end else begin
            state_d    = StBus;
            bus_addr_d = {req_addr[31:2], 2'b00};
            bus_be_d   = req_be;
          end
        end
      end
      StBus: begin
        // An ack on the terminal-count cycle still wins over the timeout.
        if (bus_ack) begin
          state_d    = StResp;
          rsp_data_d = ext_data;
          rsp_exc_d  = ExcNone;
        end else if (cnt_q == CntLast) begin
          state_d    = StResp;
          rsp_data_d = 32'h0;
          rsp_exc_d  = ExcTimeout;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lsb_q      <= 2'b00;
      ltype_q    <= 3'b000;
      bus_addr_q <= 32'h0;
      bus_be_q   <= 4'h0;
      rsp_data_q <= 32'h0;
      rsp_exc_q  <= ExcNone;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lsb_q      <= lsb_d;
      ltype_q    <= ltype_d;
      bus_addr_q <= bus_addr_d;
      bus_be_q   <= bus_be_d;
      rsp_data_q <= rsp_data_d;
      rsp_exc_q  <= rsp_exc_d;
    end
  end

  // Ready is masked by reset so it only rises once reset is released.
  assign req_ready = (state_q == StIdle) && reset_n;
  assign bus_rd    = (state_q == StBus);
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_exc   = rsp_exc_q;
  assign busy      = (state_q != StIdle);

endmodule
